// File: rtl/max_pooling_layer.sv
// Spatial max-pooling stage: POOL_SIZE x POOL_SIZE windows, stride POOL_SIZE, all channels per beat.
// Latency: one pooled beat 1 clk after the accepting edge of the window's last pixel.
// Backpressure: none; clk_en low freezes state, downstream must take every out_valid pulse.
//
// Ports:
//   clk, rst_n (async active-low), clk_en (global stall), in_valid/input_data (raster pixel stream,
//   channel c at [D_WIDTH*c +: D_WIDTH]), output_data (pooled pixel, same packing),
//   out_valid (1-cycle pulse per pooled pixel), frame_done (1-cycle pulse with last pooled pixel).
// Optional build macro: RELU_FUSE_EN -- negative inputs are clamped to 0 before pooling.
module max_pooling_layer #(
  parameter int D_WIDTH   = 16,
  parameter int CHANNELS  = 8,
  parameter int MAP_SIZE  = 24,
  parameter int POOL_SIZE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        in_valid,
  input  logic [D_WIDTH*CHANNELS-1:0] input_data,
  output logic [D_WIDTH*CHANNELS-1:0] output_data,
  output logic                        out_valid,
  output logic                        frame_done
);

  localparam int NWIN = MAP_SIZE / POOL_SIZE;
  localparam int BW   = D_WIDTH * CHANNELS;
  localparam int PW   = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(POOL_SIZE - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(NWIN - 1);

  generate
    if (MAP_SIZE % POOL_SIZE != 0) begin : g_cfg_err
      $error("max_pooling_layer: MAP_SIZE must be a multiple of POOL_SIZE");
    end
  endgenerate

  // Position is kept as (window index, phase inside window) for both axes,
  // which avoids dividers: col = wcol*P + cph, row = wrow*P + rph.
  logic [PW-1:0] cph_q, cph_d;
  logic [PW-1:0] rph_q, rph_d;
  logic [WW-1:0] wcol_q, wcol_d;
  logic [WW-1:0] wrow_q, wrow_d;

  logic [BW-1:0] h_max_q, h_max_d;
  logic [BW-1:0] out_dat_q, out_dat_d;
  logic          out_vld_q, out_vld_d;
  logic          frame_done_q, frame_done_d;

  // Row-partial maxima, one entry per horizontal window. Always written
  // (row phase 0) before being read, so no reset is needed.
  logic [BW-1:0] row_buf_q [NWIN];

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_done;
  logic          frame_last;
  logic [BW-1:0] rb_rd;
  logic [BW-1:0] m_vec;
  logic [BW-1:0] merge_vec;

  logic signed [D_WIDTH-1:0] in_c;
  logic signed [D_WIDTH-1:0] hm_c;
  logic signed [D_WIDTH-1:0] rb_c;
  logic signed [D_WIDTH-1:0] m_c;

  function automatic logic signed [D_WIDTH-1:0] smax(input logic signed [D_WIDTH-1:0] a,
                                                     input logic signed [D_WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  assign accept     = clk_en & in_valid;
  assign col_last   = (cph_q == PH_LAST);
  assign row_last   = (rph_q == PH_LAST);
  assign win_done   = col_last & row_last;
  assign frame_last = (wcol_q == WIN_LAST) && (wrow_q == WIN_LAST);
  assign rb_rd      = row_buf_q[wcol_q];

  // Per-channel datapath. m is the running horizontal max including the
  // current pixel; merge folds it into the row buffer (first row of the
  // window overwrites). merge doubles as the pooled result on window completion.
  always_comb begin
    m_vec     = '0;
    merge_vec = '0;
    in_c      = '0;
    hm_c      = '0;
    rb_c      = '0;
    m_c       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_c = $signed(input_data[c*D_WIDTH +: D_WIDTH]);
`ifdef RELU_FUSE_EN
      if (in_c < 0) begin
        in_c = '0;
      end
`else
      in_c = in_c;
`endif
      hm_c = $signed(h_max_q[c*D_WIDTH +: D_WIDTH]);
      rb_c = $signed(rb_rd[c*D_WIDTH +: D_WIDTH]);
      m_c  = (cph_q == '0) ? in_c : smax(hm_c, in_c);
      m_vec[c*D_WIDTH +: D_WIDTH]     = m_c;
      merge_vec[c*D_WIDTH +: D_WIDTH] = (rph_q == '0) ? m_c : smax(rb_c, m_c);
    end
  end

  always_comb begin
    cph_d  = cph_q;
    rph_d  = rph_q;
    wcol_d = wcol_q;
    wrow_d = wrow_q;
    if (accept) begin
      if (col_last) begin
        cph_d = '0;
        if (wcol_q == WIN_LAST) begin
          wcol_d = '0;
          if (row_last) begin
            rph_d  = '0;
            wrow_d = (wrow_q == WIN_LAST) ? '0 : wrow_q + 1'b1;
          end else begin
            rph_d = rph_q + 1'b1;
          end
        end else begin
          wcol_d = wcol_q + 1'b1;
        end
      end else begin
        cph_d = cph_q + 1'b1;
      end
    end
  end

  always_comb begin
    h_max_d      = accept ? m_vec : h_max_q;
    out_dat_d    = (accept && win_done) ? merge_vec : out_dat_q;
    // Pulses are recomputed every edge, so a stalled cycle still clears them.
    out_vld_d    = accept & win_done;
    frame_done_d = accept & win_done & frame_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cph_q        <= '0;
      rph_q        <= '0;
      wcol_q       <= '0;
      wrow_q       <= '0;
      h_max_q      <= '0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cph_q        <= cph_d;
      rph_q        <= rph_d;
      wcol_q       <= wcol_d;
      wrow_q       <= wrow_d;
      h_max_q      <= h_max_d;
      out_dat_q    <= out_dat_d;
      out_vld_q    <= out_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && col_last) begin
      row_buf_q[wcol_q] <= merge_vec;
    end
  end

  assign output_data = out_dat_q;
  assign out_valid   = out_vld_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Directed bench for max_pooling_layer at D_WIDTH=8, CHANNELS=2, MAP_SIZE=4, POOL_SIZE=2.
// Channel 1 mirrors channel 0 except in the multi-channel scenario.
// Pooled beats are captured on the falling edge together with the accept count at that time.
module tb_max_pooling_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] input_data = '0;
  logic [15:0] output_data;
  logic        out_valid;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] dat_q[$];
  bit          fd_q[$];
  int          acc_q[$];
  int          acc_cnt = 0;
  int          hi_cnt = 0;
  int          rise_cnt = 0;
  bit          prev_ov = 1'b0;

  max_pooling_layer #(
    .D_WIDTH(8), .CHANNELS(2), .MAP_SIZE(4), .POOL_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
    .input_data(input_data), .output_data(output_data),
    .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && clk_en && in_valid) acc_cnt++;

  always @(negedge clk) begin
    if (out_valid) begin
      dat_q.push_back(output_data);
      fd_q.push_back(frame_done);
      acc_q.push_back(acc_cnt);
      hi_cnt++;
      if (!prev_ov) rise_cnt++;
    end
    prev_ov = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    dat_q.delete(); fd_q.delete(); acc_q.delete();
    acc_cnt = 0; hi_cnt = 0; rise_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clk_en   = 1'b1;
    end
  endtask

  // Presents one pixel and holds it until a clk_en-high edge takes it.
  task automatic send(input logic [7:0] c0, input logic [7:0] c1, input bit gaps);
    int tries;
    if (gaps) begin
      @(negedge clk);
      in_valid = 1'b0;
      clk_en   = 1'($urandom_range(0, 1));
    end
    tries = 0;
    do begin
      @(negedge clk);
      in_valid   = 1'b1;
      input_data = {c1, c0};
      clk_en     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      tries++;
    end while (!clk_en && tries < 20);
    clk_en = 1'b1;
  endtask

  // kind 0: i, 1: i-16, 2: 15-i, 3: ch0=i ch1=-i
  task automatic frame(input int kind, input bit gaps);
    logic [7:0] c0, c1;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        1:       c0 = 8'(i - 16);
        2:       c0 = 8'(15 - i);
        default: c0 = 8'(i);
      endcase
      c1 = (kind == 3) ? 8'(-i) : c0;
      send(c0, c1, gaps);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++;
    if (output_data !== 16'h0000) begin errors++; $display("FAIL reset_output_data got %h exp 0000", output_data); end
  endtask

  task automatic test_raster();
    logic [7:0] e[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    int         a[4] = '{6, 8, 14, 16};
    clear_log();
    frame(0, 1'b0);
    idle(3);
    checks++;
    if (dat_q.size() != 4) begin errors++; $display("FAIL raster_count got %0d exp 4", dat_q.size()); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e[i], e[i]}) begin errors++; $display("FAIL raster_data[%0d] got %h exp %h", i, dat_q[i], {e[i], e[i]}); end
      checks++;
      if (acc_q[i] != a[i]) begin errors++; $display("FAIL raster_latency[%0d] got accept %0d exp %0d", i, acc_q[i], a[i]); end
      checks++;
      if (fd_q[i] !== (i == 3)) begin errors++; $display("FAIL raster_frame_done[%0d] got %b exp %b", i, fd_q[i], (i == 3)); end
    end
    checks++;
    if (output_data !== 16'h0F0F) begin errors++; $display("FAIL raster_hold got %h exp 0f0f", output_data); end
  endtask

  task automatic test_negative();
`ifdef RELU_FUSE_EN
    logic [7:0] e[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
    logic [7:0] e[4] = '{8'hF5, 8'hF7, 8'hFD, 8'hFF};
`endif
    clear_log();
    frame(1, 1'b0);
    idle(3);
    checks++;
    if (dat_q.size() != 4) begin errors++; $display("FAIL negative_count got %0d exp 4", dat_q.size()); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e[i], e[i]}) begin errors++; $display("FAIL negative_data[%0d] got %h exp %h", i, dat_q[i], {e[i], e[i]}); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    int         a[4] = '{6, 8, 14, 16};
    clear_log();
    frame(0, 1'b1);
    idle(3);
    checks++;
    if (rise_cnt != 4) begin errors++; $display("FAIL stall_pulses got %0d exp 4", rise_cnt); end
    checks++;
    if (hi_cnt != 4) begin errors++; $display("FAIL stall_pulse_width got %0d high cycles exp 4", hi_cnt); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e[i], e[i]}) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, dat_q[i], {e[i], e[i]}); end
      checks++;
      if (acc_q[i] != a[i]) begin errors++; $display("FAIL stall_latency[%0d] got accept %0d exp %0d", i, acc_q[i], a[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    clear_log();
    for (int i = 0; i < 7; i++) send(8'(i), 8'(i), 1'b0);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    checks++;
    if (output_data !== 16'h0505) begin errors++; $display("FAIL midreset_pre got %h exp 0505", output_data); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (output_data !== 16'h0000) begin errors++; $display("FAIL midreset_async_clear got %h exp 0000", output_data); end
    idle(2);
    rst_n = 1'b1;
    clear_log();
    frame(0, 1'b0);
    idle(3);
    checks++;
    if (dat_q.size() != 4) begin errors++; $display("FAIL midreset_count got %0d exp 4", dat_q.size()); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e[i], e[i]}) begin errors++; $display("FAIL midreset_data[%0d] got %h exp %h", i, dat_q[i], {e[i], e[i]}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[8] = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd15, 8'd13, 8'd7, 8'd5};
    int         a[8] = '{6, 8, 14, 16, 22, 24, 30, 32};
    int         nfd;
    clear_log();
    frame(0, 1'b0);
    frame(2, 1'b0);
    idle(3);
    nfd = 0;
    checks++;
    if (dat_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", dat_q.size()); end
    for (int i = 0; i < 8 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e[i], e[i]}) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, dat_q[i], {e[i], e[i]}); end
      checks++;
      if (acc_q[i] != a[i]) begin errors++; $display("FAIL b2b_latency[%0d] got accept %0d exp %0d", i, acc_q[i], a[i]); end
      checks++;
      if (fd_q[i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_frame_done[%0d] got %b exp %b", i, fd_q[i], (i == 3 || i == 7)); end
      if (fd_q[i]) nfd++;
    end
    checks++;
    if (nfd != 2) begin errors++; $display("FAIL b2b_frame_done_count got %0d exp 2", nfd); end
  endtask

  task automatic test_channels();
    logic [7:0] e0[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
`ifdef RELU_FUSE_EN
    logic [7:0] e1[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
    logic [7:0] e1[4] = '{8'h00, 8'hFE, 8'hF8, 8'hF6};
`endif
    clear_log();
    frame(3, 1'b0);
    idle(3);
    checks++;
    if (dat_q.size() != 4) begin errors++; $display("FAIL channels_count got %0d exp 4", dat_q.size()); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== {e1[i], e0[i]}) begin errors++; $display("FAIL channels_data[%0d] got %h exp %h", i, dat_q[i], {e1[i], e0[i]}); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    test_raster();
    test_negative();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_channels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
